// File: rtl/imm_decode_stage_if.sv
// Handshake bundle for imm_decode_stage: the fetch-side input channel and the execute-side output channel.
// The master modport is the fetch/execute environment; the slave modport is the decode stage.
interface imm_decode_stage_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_type;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_instr, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_type, out_illegal, out_tag
  );

  modport slave (
    input  in_valid, in_instr, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_type, out_illegal, out_tag
  );
endinterface

// File: rtl/imm_decode_stage.sv
// Immediate decode stage: classifies the RV immediate format from the opcode, builds the extended
// immediate and buffers {imm, type, illegal, tag} in a 2-entry FIFO. Optional macro: IMM_DECODE_ZICSR_EN.
module imm_decode_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input logic               clk,
  input logic               rst,
  input logic               flush,
  imm_decode_stage_if.slave bus
);

  localparam logic [2:0] TY_NONE = 3'd0;
  localparam logic [2:0] TY_I    = 3'd1;
  localparam logic [2:0] TY_S    = 3'd2;
  localparam logic [2:0] TY_B    = 3'd3;
  localparam logic [2:0] TY_U    = 3'd4;
  localparam logic [2:0] TY_J    = 3'd5;
  localparam logic [2:0] TY_Z    = 3'd6;

  localparam bit IS_RV64 = (XLEN == 64);

  logic [31:0]      w_instr;
  logic [6:0]       w_opcode;
  logic [2:0]       w_type;
  logic             w_illegal;
  logic [31:0]      w_imm32;
  logic [XLEN-1:0]  w_imm;

  assign w_instr  = bus.in_instr;
  assign w_opcode = w_instr[6:0];

  always_comb begin
    w_type    = TY_NONE;
    w_illegal = 1'b0;
    case (w_opcode)
      7'b0110111, 7'b0010111:             w_type = TY_U;
      7'b1101111:                         w_type = TY_J;
      7'b1100111, 7'b0000011, 7'b0010011: w_type = TY_I;
      7'b0011011: begin
        if (IS_RV64) w_type = TY_I;
        else         w_illegal = 1'b1;
      end
      7'b0100011:                         w_type = TY_S;
      7'b1100011:                         w_type = TY_B;
      7'b0110011:                         w_type = TY_NONE;
      7'b0111011:                         w_illegal = !IS_RV64;
      7'b1110011: begin
`ifdef IMM_DECODE_ZICSR_EN
        w_type = w_instr[14] ? TY_Z : TY_I;
`else
        w_type = TY_I;
`endif
      end
      default:                            w_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_imm32 = '0;
    case (w_type)
      TY_I: w_imm32 = {{20{w_instr[31]}}, w_instr[31:20]};
      TY_S: w_imm32 = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
      TY_B: w_imm32 = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25],
                       w_instr[11:8], 1'b0};
      TY_U: w_imm32 = {w_instr[31:12], 12'b0};
      TY_J: w_imm32 = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20],
                       w_instr[30:21], 1'b0};
      TY_Z: w_imm32 = {27'b0, w_instr[19:15]};
      default: w_imm32 = '0;
    endcase
  end

  // Every 32-bit form already carries its correct top bit (zero for Z and NONE),
  // so a plain sign-extension to XLEN covers all formats.
  assign w_imm = XLEN'($signed(w_imm32));

  logic [1:0]       r_count;
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [XLEN-1:0]  r_imm_mem     [2];
  logic [2:0]       r_type_mem    [2];
  logic             r_illegal_mem [2];
  logic [TAG_W-1:0] r_tag_mem     [2];

  logic w_in_ready;
  logic w_out_valid;
  logic w_push;
  logic w_pop;

  assign w_in_ready  = (r_count < 2'd2) && !rst;
  assign w_out_valid = (r_count != 2'd0);
  assign w_push      = bus.in_valid && w_in_ready && !flush;
  assign w_pop       = w_out_valid && bus.out_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      r_count  <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      r_wr_ptr <= r_wr_ptr ^ w_push;
      r_rd_ptr <= r_rd_ptr ^ w_pop;
    end
  end

  // Payload storage is never reset; an empty FIFO masks it at the outputs.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_imm_mem[r_wr_ptr]     <= w_imm;
      r_type_mem[r_wr_ptr]    <= w_type;
      r_illegal_mem[r_wr_ptr] <= w_illegal;
      r_tag_mem[r_wr_ptr]     <= bus.in_tag;
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = w_out_valid;
  assign bus.out_imm     = w_out_valid ? r_imm_mem[r_rd_ptr]     : '0;
  assign bus.out_type    = w_out_valid ? r_type_mem[r_rd_ptr]    : TY_NONE;
  assign bus.out_illegal = w_out_valid ? r_illegal_mem[r_rd_ptr] : 1'b0;
  assign bus.out_tag     = w_out_valid ? r_tag_mem[r_rd_ptr]     : '0;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: a 32-bit and a 64-bit instance share clock and reset;
// decode vectors go to both, handshake/flush/reset scenarios run on the 32-bit instance.
module tb_imm_decode_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush32 = 1'b0;
  logic flush64 = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  imm_decode_stage_if #(.XLEN(32), .TAG_W(32)) b32 ();
  imm_decode_stage_if #(.XLEN(64), .TAG_W(32)) b64 ();

  imm_decode_stage #(.XLEN(32), .TAG_W(32)) u_dut32 (
    .clk(clk), .rst(rst), .flush(flush32), .bus(b32.slave)
  );
  imm_decode_stage #(.XLEN(64), .TAG_W(32)) u_dut64 (
    .clk(clk), .rst(rst), .flush(flush64), .bus(b64.slave)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Present one instruction to both instances for one edge; both have out_ready = 1 here.
  task automatic send(input logic [31:0] instr, input logic [31:0] tag);
    b32.in_valid = 1'b1; b32.in_instr = instr; b32.in_tag = tag;
    b64.in_valid = 1'b1; b64.in_instr = instr; b64.in_tag = tag;
    @(posedge clk); #1;
    b32.in_valid = 1'b0;
    b64.in_valid = 1'b0;
    $display("[TB] send instr=0x%08h tag=0x%0h", instr, tag);
  endtask

  task automatic offer32(input logic [31:0] instr, input logic [31:0] tag);
    b32.in_valid = 1'b1; b32.in_instr = instr; b32.in_tag = tag;
  endtask

  task automatic check32(input string name, input logic [31:0] imm, input logic [2:0] ty,
                         input logic ill, input logic [31:0] tag);
    check({name, "_valid"}, 64'(b32.out_valid), 64'd1);
    check({name, "_imm"}, 64'(b32.out_imm), 64'(imm));
    check({name, "_type"}, 64'(b32.out_type), 64'(ty));
    check({name, "_ill"}, 64'(b32.out_illegal), 64'(ill));
    check({name, "_tag"}, 64'(b32.out_tag), 64'(tag));
  endtask

  task automatic check64(input string name, input logic [63:0] imm, input logic [2:0] ty,
                         input logic ill);
    check({name, "_valid64"}, 64'(b64.out_valid), 64'd1);
    check({name, "_imm64"}, b64.out_imm, imm);
    check({name, "_type64"}, 64'(b64.out_type), 64'(ty));
    check({name, "_ill64"}, 64'(b64.out_illegal), 64'(ill));
  endtask

  initial begin
    logic [31:0] q[$];
    logic acc, popd;
    logic [31:0] tg;

    b32.in_valid = 1'b0; b32.in_instr = '0; b32.in_tag = '0; b32.out_ready = 1'b1;
    b64.in_valid = 1'b0; b64.in_instr = '0; b64.in_tag = '0; b64.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(b32.out_valid), 64'd0);
    check("rst_imm", 64'(b32.out_imm), 64'd0);
    check("rst_type", 64'(b32.out_type), 64'd0);
    check("rst_ill", 64'(b32.out_illegal), 64'd0);
    check("rst_tag", 64'(b32.out_tag), 64'd0);
    check("rst_in_ready", 64'(b32.in_ready), 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(b32.in_ready), 64'd1);

    // Decode vectors, consecutive pushes with out_ready = 1
    send(32'hFFF00093, 32'h100);
    check32("addi", 32'hFFFFFFFF, 3'd1, 1'b0, 32'h100);
    check64("addi", 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
    send(32'hFE112E23, 32'h104);
    check32("sw", 32'hFFFFFFFC, 3'd2, 1'b0, 32'h104);
    send(32'h800002B7, 32'h108);
    check32("lui", 32'h80000000, 3'd4, 1'b0, 32'h108);
    check64("lui", 64'hFFFFFFFF80000000, 3'd4, 1'b0);
    send(32'h12345097, 32'h10C);
    check32("auipc", 32'h12345000, 3'd4, 1'b0, 32'h10C);
    send(32'hFE000EE3, 32'h110);
    check32("beq", 32'hFFFFFFFC, 3'd3, 1'b0, 32'h110);
    send(32'h0010006F, 32'h114);
    check32("jal", 32'h00000800, 3'd5, 1'b0, 32'h114);
    send(32'h3002D073, 32'h118);
`ifdef IMM_DECODE_ZICSR_EN
    check32("csrrwi", 32'h5, 3'd6, 1'b0, 32'h118);
`else
    check32("csrrwi", 32'h300, 3'd1, 1'b0, 32'h118);
`endif
    send(32'h0000007F, 32'h11C);
    check32("illegal", 32'h0, 3'd0, 1'b1, 32'h11C);
    send(32'h0010009B, 32'h120);
    check32("addiw", 32'h0, 3'd0, 1'b1, 32'h120);
    check64("addiw", 64'h1, 3'd1, 1'b0);
    send(32'h002081B3, 32'h124);
    check32("add", 32'h0, 3'd0, 1'b0, 32'h124);
    @(posedge clk); #1;
    check("drain_valid", 64'(b32.out_valid), 64'd0);

    // Backpressure: A, B accepted, C held, outputs stable on A
    b32.out_ready = 1'b0;
    offer32(32'hFFF00093, 32'hA);
    @(posedge clk); #1;
    check("bp_ready_after_a", 64'(b32.in_ready), 64'd1);
    offer32(32'hFE112E23, 32'hB);
    @(posedge clk); #1;
    offer32(32'h800002B7, 32'hC);
    check("bp_full_ready", 64'(b32.in_ready), 64'd0);
    check("bp_head_a", 64'(b32.out_tag), 64'hA);
    @(posedge clk); #1;
    check("bp_hold_ready", 64'(b32.in_ready), 64'd0);
    check("bp_hold_tag", 64'(b32.out_tag), 64'hA);
    check("bp_hold_imm", 64'(b32.out_imm), 64'hFFFFFFFF);
    b32.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      acc  = b32.in_valid && b32.in_ready;
      popd = b32.out_valid;
      tg   = b32.out_tag;
      @(posedge clk); #1;
      if (popd) q.push_back(tg);
      if (acc) b32.in_valid = 1'b0;
    end
    $display("[TB] backpressure drained %0d entries", q.size());
    check("bp_count", 64'(q.size()), 64'd3);
    if (q.size() == 3) begin
      check("bp_order0", 64'(q[0]), 64'hA);
      check("bp_order1", 64'(q[1]), 64'hB);
      check("bp_order2", 64'(q[2]), 64'hC);
    end

    // Flush with a full FIFO, input offered in the same cycle
    b32.out_ready = 1'b0;
    offer32(32'hFFF00093, 32'h21);
    @(posedge clk); #1;
    offer32(32'hFFF00093, 32'h22);
    @(posedge clk); #1;
    offer32(32'hFFF00093, 32'hF1);
    flush32 = 1'b1;
    @(posedge clk); #1;
    flush32 = 1'b0; b32.in_valid = 1'b0;
    $display("[TB] flush at count 2");
    check("flush2_valid", 64'(b32.out_valid), 64'd0);
    check("flush2_ready", 64'(b32.in_ready), 64'd1);
    @(posedge clk); #1;
    check("flush2_dropped", 64'(b32.out_valid), 64'd0);

    // Flush at count 1 while in_ready = 1: offered input still dropped
    offer32(32'hFFF00093, 32'h31);
    @(posedge clk); #1;
    offer32(32'hFFF00093, 32'hF2);
    flush32 = 1'b1;
    check("flush1_ready_pre", 64'(b32.in_ready), 64'd1);
    @(posedge clk); #1;
    flush32 = 1'b0; b32.in_valid = 1'b0;
    $display("[TB] flush at count 1");
    check("flush1_valid", 64'(b32.out_valid), 64'd0);
    @(posedge clk); #1;
    check("flush1_dropped", 64'(b32.out_valid), 64'd0);

    // Reset mid-stream
    offer32(32'hFFF00093, 32'h55);
    @(posedge clk); #1;
    b32.in_valid = 1'b0;
    check("mid_pre_valid", 64'(b32.out_valid), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    $display("[TB] reset mid-stream");
    check("mid_valid", 64'(b32.out_valid), 64'd0);
    check("mid_imm", 64'(b32.out_imm), 64'd0);
    check("mid_type", 64'(b32.out_type), 64'd0);
    check("mid_ill", 64'(b32.out_illegal), 64'd0);
    check("mid_tag", 64'(b32.out_tag), 64'd0);
    check("mid_in_ready", 64'(b32.in_ready), 64'd0);
    rst = 1'b0;
    #1;
    check("mid_post_ready", 64'(b32.in_ready), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
